fir_tap_mac_seq: RTL
====================

// Module: fir_tap_mac_seq
// PURPOSE
//  Time-multiplexed direct-form FIR tap engine; sits directly upstream of the 16-bit
//  prefix adder (pparch_koggstone16) and feeds it accumulator/product operand pairs.
//  Holds the sample delay line, forms one tap product per cycle, and accumulates
//  through the external adder. Gating the adder operands when idle cuts switching power.
// PARAMETERS
//  N_TAPS   4   number of FIR taps (>=2); one adder pass per tap
//  DATA_W   8   unsigned sample width
//  COEF_W   8   unsigned coefficient width; DATA_W+COEF_W must equal 16
// PORTS
//  clk        in   1               rising-edge clock
//  rst_n      in   1               asynchronous active-low reset
//  clr        in   1               sync clear: zero delay line and acc, go IDLE
//  coeffs     in   N_TAPS*COEF_W   static taps, c[k] = coeffs[k*COEF_W +: COEF_W]
//  in_valid   in   1               input sample valid
//  in_ready   out  1               block can accept a sample
//  in_data    in   DATA_W          input sample x[n]
//  add_a      out  16              adder operand a (accumulator)
//  add_b      out  16              adder operand b (tap product)
//  add_sum    in   16              adder result, combinational from add_a/add_b
//  out_valid  out  1               filtered result valid
//  out_ready  in   1               downstream accepts result
//  out_data   out  16              y[n] = sum c[k]*x[n-k], modulo 2^16
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; delay line x[0..N_TAPS-1]=0; acc=0; idx=0;
//   out_valid=0; out_data=0; add_a=add_b=0. in_ready reflects state (1 in IDLE).
//  FSM states: IDLE, MAC, DONE.
//  Transfer-in occurs on any edge where in_valid && in_ready:
//   x[0]<=in_data, x[k]<=x[k-1]; acc<=0; idx<=0; state<=MAC.
//  IDLE: in_ready=1; add_a=add_b=0.
//  MAC: add_a=acc; add_b=x[idx]*c[idx] (16-bit unsigned product);
//   each edge acc<=add_sum, idx<=idx+1. Last tap (idx==N_TAPS-1) -> DONE; idx<=0.
//   in_ready=0. Exactly N_TAPS MAC cycles.
//  DONE: out_valid=1; out_data=acc (registered, stable while out_valid && !out_ready);
//   add_a=add_b=0.
//   in_ready=out_ready (combinational). out_ready=1 and in_valid=1 on the same
//   edge: result retires and the new sample is transferred, so state<=MAC directly.
//   out_ready=1 with in_valid=0: state<=IDLE, out_valid drops next cycle.
//  Latency: transfer-in edge T; out_valid=1 in the cycle after edge T+N_TAPS.
//   Sustained throughput: one result per N_TAPS+1 cycles.
//  Arithmetic: unsigned throughout. The adder has no carry-out, so acc wraps modulo
//   2^16 with no saturation and no overflow flag.
//  clr: highest priority after reset. Takes effect on the next edge in any state and
//   aborts any in-flight MAC: x[*]=0, acc=0, idx=0, out_valid=0, state=IDLE.
//   in_valid on that edge is ignored.
//  rst_n mid-MAC: immediate return to reset values; the partial result is discarded
//   and never presented.
//  Delay-line history persists across results; only reset or clr zero it.
// TESTING (bench instantiates the real pparch_koggstone16 on add_a/add_b/add_sum;
//   N_TAPS=4, coeffs c0..c3 = 1,2,3,4 unless stated)
//  1 Impulse: samples 1,0,0,0 with out_ready=1 -> out_data 1,2,3,4; each out_valid
//    4 cycles after its accept.
//  2 Step: samples 10,10,10,10 -> out_data 10,30,60,100.
//  3 Wrap: all c=255, samples 255 x4 -> last out_data 63492 (260100 mod 65536),
//    no X, no flag.
//  4 Backpressure: out_ready=0 for 5 cycles in DONE -> out_data held constant,
//    in_ready=0 with in_valid=1, no sample lost. Then in_valid and out_ready rise
//    together -> same-edge retire and accept, state goes straight to MAC.
//  5 Abort: clr pulse at MAC idx=2 -> no out_valid. Next sample 7 -> out_data 7.
//    rst_n low mid-MAC -> all outputs 0 asynchronously.
//  6 Power gating: add_a and add_b remain 0 throughout IDLE and DONE (assertion).

Source files
------------

// File: rtl/fir_tap_mac_seq.sv
// fir_tap_mac_seq: time-multiplexed FIR tap engine, one tap product per cycle accumulated through an external adder.
module fir_tap_mac_seq #(
    parameter int N_TAPS = 4,
    parameter int DATA_W = 8,
    parameter int COEF_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic [N_TAPS*COEF_W-1:0]   coeffs,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_data,
    output logic [15:0]                add_a,
    output logic [15:0]                add_b,
    input  logic [15:0]                add_sum,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [15:0]                out_data
);
    localparam int IW = $clog2(N_TAPS);
    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;
    state_t            state;
    logic [DATA_W-1:0] x [N_TAPS];
    logic [15:0]       acc;
    logic [IW-1:0]     idx;
    logic [COEF_W-1:0] coef;
    logic [15:0]       prod;
    logic              last;
    assign coef      = coeffs[idx*COEF_W +: COEF_W];
    assign prod      = {{(16-DATA_W){1'b0}}, x[idx]} * {{(16-COEF_W){1'b0}}, coef};
    assign last      = idx == IW'(N_TAPS-1);
    assign in_ready  = (state == IDLE) || (state == DONE && out_ready);
    assign out_valid = state == DONE;
    assign out_data  = acc;
    // adder operands held at zero outside MAC to keep the adder quiet
    assign add_a     = state == MAC ? acc : 16'd0;
    assign add_b     = state == MAC ? prod : 16'd0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            idx   <= '0;
            for (int k = 0; k < N_TAPS; k++) x[k] <= '0;
        end else if (clr) begin
            state <= IDLE;
            acc   <= '0;
            idx   <= '0;
            for (int k = 0; k < N_TAPS; k++) x[k] <= '0;
        end else if (in_valid && in_ready) begin
            x[0] <= in_data;
            for (int k = 1; k < N_TAPS; k++) x[k] <= x[k-1];
            acc   <= '0;
            idx   <= '0;
            state <= MAC;
        end else if (state == MAC) begin
            acc   <= add_sum;
            idx   <= last ? '0 : idx + 1'b1;
            state <= last ? DONE : MAC;
        end else if (state == DONE && out_ready) begin
            state <= IDLE;
        end
    end
endmodule
